// File: rtl/dsp_pkg.sv
// Shared Q15 constants, FSM state type and bar-level width for the band level meter.
package dsp_pkg;

  localparam int Q_FP = 15;
  localparam logic [Q_FP-1:0] MAG_MAX = 15'h7FFF;
  localparam int LEVEL_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ABS    = 2'd1,
    S_UPDATE = 2'd2,
    S_QUANT  = 2'd3
  } state_e;

endpackage

// File: rtl/msb_index_enc.sv
// Combinational 15-bit priority encoder: MSB index, the bit just below it, and a non-zero flag.
module msb_index_enc (
  input  logic [14:0] i_val,
  output logic [3:0]  o_idx,
  output logic        o_below,
  output logic        o_nz
);

  always_comb begin
    o_idx = 4'd0;
    o_nz  = |i_val;
    // Ascending scan: the last set bit seen is the MSB.
    for (int i = 0; i < 15; i++) begin
      if (i_val[i]) o_idx = 4'(i);
    end
    o_below = (o_idx != 4'd0) ? i_val[o_idx - 4'd1] : 1'b0;
  end

endmodule

// File: rtl/band_level_meter.sv
// Envelope follower with peak-hold/decay, log2 bar level, peak and clip tracking.
// Define BAND_LEVEL_METER_HALFSTEP_EN for half-step (about 3 dB) bar resolution.
//
// state    | meaning
// S_IDLE   | waiting for i_valid, sample captured on accept
// S_ABS    | saturating magnitude, peak/clip update
// S_UPDATE | envelope attack / hold / decay
// S_QUANT  | bar level computed, outputs published
module band_level_meter
  import dsp_pkg::*;
#(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned DECAY_SHIFT  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [15:0]        i_data,
  input  logic               i_peak_clr,
  output logic [LEVEL_W-1:0] o_level,
  output logic [Q_FP-1:0]    o_env,
  output logic [Q_FP-1:0]    o_peak,
  output logic               o_clip,
  output logic               o_valid,
  output logic               o_overrun
);

  state_e             state_q, state_d;
  logic [15:0]        sample_q, sample_d;
  logic [Q_FP-1:0]    mag_q, mag_d;
  logic [Q_FP-1:0]    env_q, env_d;
  logic [15:0]        hold_q, hold_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [Q_FP-1:0]    env_out_q, env_out_d;
  logic [Q_FP-1:0]    peak_q, peak_d;
  logic               clip_q, clip_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic [Q_FP-1:0]    abs_mag;
  logic [Q_FP-1:0]    decay_raw;
  logic [Q_FP-1:0]    decay;
  logic [3:0]         msb_idx;
  logic               below_bit;
  logic               env_nz;
  logic [LEVEL_W-1:0] level_calc;

  msb_index_enc u_msb_enc (
    .i_val   (env_q),
    .o_idx   (msb_idx),
    .o_below (below_bit),
    .o_nz    (env_nz)
  );

  // -32768 has no positive Q15 counterpart, so it saturates to full scale.
  always_comb begin
    if (!sample_q[15])              abs_mag = sample_q[14:0];
    else if (sample_q == 16'h8000)  abs_mag = MAG_MAX;
    else                            abs_mag = 15'(16'd0 - sample_q);
  end

  // Minimum step of one keeps small envelopes decaying all the way to zero.
  always_comb begin
    decay_raw = env_q >> DECAY_SHIFT;
    decay     = ((decay_raw == '0) && (env_q != '0)) ? 15'd1 : decay_raw;
  end

`ifdef BAND_LEVEL_METER_HALFSTEP_EN
  always_comb begin
    level_calc = '0;
    if (env_nz) level_calc = LEVEL_W'({msb_idx, 1'b0}) + 5'd1 + LEVEL_W'(below_bit);
  end
`else
  logic unused_below;
  assign unused_below = below_bit;

  always_comb begin
    level_calc = '0;
    if (env_nz) level_calc = LEVEL_W'(msb_idx) + 5'd1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    mag_d     = mag_q;
    env_d     = env_q;
    hold_d    = hold_q;
    level_d   = level_q;
    env_out_d = env_out_q;
    peak_d    = peak_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (i_valid && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          sample_d = i_data;
          state_d  = S_ABS;
        end
      end
      S_ABS: begin
        mag_d = abs_mag;
        if (abs_mag > peak_q)   peak_d = abs_mag;
        if (abs_mag == MAG_MAX) clip_d = 1'b1;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (mag_q >= env_q) begin
          env_d  = mag_q;
          hold_d = 16'(HOLD_SAMPLES);
        end else if (hold_q != '0) begin
          hold_d = hold_q - 16'd1;
        end else begin
          env_d = env_q - decay;
        end
        state_d = S_QUANT;
      end
      S_QUANT: begin
        level_d   = level_calc;
        env_out_d = env_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A clear coinciding with the S_ABS peak update takes precedence.
    if (i_peak_clr) begin
      peak_d = '0;
      clip_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sample_q  <= '0;
      mag_q     <= '0;
      env_q     <= '0;
      hold_q    <= '0;
      level_q   <= '0;
      env_out_q <= '0;
      peak_q    <= '0;
      clip_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      mag_q     <= mag_d;
      env_q     <= env_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      env_out_q <= env_out_d;
      peak_q    <= peak_d;
      clip_q    <= clip_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_level   = level_q;
  assign o_env     = env_out_q;
  assign o_peak    = peak_q;
  assign o_clip    = clip_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_band_level_meter.sv
// Bench for band_level_meter: three instances with different hold/decay settings share one stimulus.
module tb_band_level_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] data;
  logic        clr;

  logic [4:0]  lvl  [3];
  logic [14:0] env  [3];
  logic [14:0] peak [3];
  logic        clip [3];
  logic        vld  [3];
  logic        ovr  [3];

  int n_tests = 0;
  int n_fail  = 0;

  int hold_p  [3] = '{4800, 2, 0};
  int shift_p [3] = '{6, 1, 6};

  int m_env  [3];
  int m_hold [3];
  int m_peak;
  bit m_clip;
  bit m_ovr;

  logic [3:0]  o_vpat [3];
  logic [14:0] o_env  [3];
  logic [4:0]  o_lvl  [3];
  logic [14:0] o_peak [3];
  logic        o_clip [3];
  logic        o_ovr  [3];

  always #5 clk = ~clk;

  band_level_meter #(.HOLD_SAMPLES(4800), .DECAY_SHIFT(6)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_peak_clr(clr),
    .o_level(lvl[0]), .o_env(env[0]), .o_peak(peak[0]), .o_clip(clip[0]),
    .o_valid(vld[0]), .o_overrun(ovr[0]));

  band_level_meter #(.HOLD_SAMPLES(2), .DECAY_SHIFT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_peak_clr(clr),
    .o_level(lvl[1]), .o_env(env[1]), .o_peak(peak[1]), .o_clip(clip[1]),
    .o_valid(vld[1]), .o_overrun(ovr[1]));

  band_level_meter #(.HOLD_SAMPLES(0), .DECAY_SHIFT(6)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_peak_clr(clr),
    .o_level(lvl[2]), .o_env(env[2]), .o_peak(peak[2]), .o_clip(clip[2]),
    .o_valid(vld[2]), .o_overrun(ovr[2]));

  // Reference model: envelope rules applied directly to integers.
  function automatic int mag_of(input logic [15:0] d);
    int s;
    s = int'($signed(d));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  function automatic int level_of(input int e);
    int b;
    int v;
    b = 0;
    v = e;
    while (v > 0) begin
      b++;
      v = v / 2;
    end
`ifdef BAND_LEVEL_METER_HALFSTEP_EN
    if (e == 0) return 0;
    return 2 * (b - 1) + 1 + ((b >= 2) ? ((e >> (b - 2)) & 1) : 0);
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_env[k]  = 0;
      m_hold[k] = 0;
    end
    m_peak = 0;
    m_clip = 0;
    m_ovr  = 0;
  endtask

  task automatic model_sample(input logic [15:0] d, input bit clr_abs);
    int m;
    int dd;
    m = mag_of(d);
    if (clr_abs) begin
      m_peak = 0;
      m_clip = 0;
    end else begin
      if (m > m_peak) m_peak = m;
      if (m == 32767) m_clip = 1;
    end
    for (int k = 0; k < 3; k++) begin
      if (m >= m_env[k]) begin
        m_env[k]  = m;
        m_hold[k] = hold_p[k];
      end else if (m_hold[k] != 0) begin
        m_hold[k]--;
      end else begin
        dd = m_env[k] >> shift_p[k];
        if (dd == 0) dd = 1;
        m_env[k] -= dd;
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    clr   = 1'b0;
    data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the DUTs idle; returns at the negedge where o_valid should be high.
  task automatic send(input logic [15:0] d, input bit clr_abs, input bit ovr_try);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    clr   = clr_abs;
    for (int k = 0; k < 3; k++) o_vpat[k][0] = vld[k];
    @(negedge clk);
    clr = 1'b0;
    if (ovr_try) begin
      valid = 1'b1;
      data  = 16'($urandom);
    end
    for (int k = 0; k < 3; k++) o_vpat[k][1] = vld[k];
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) o_vpat[k][2] = vld[k];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o_vpat[k][3] = vld[k];
      o_env[k]     = env[k];
      o_lvl[k]     = lvl[k];
      o_peak[k]    = peak[k];
      o_clip[k]    = clip[k];
      o_ovr[k]     = ovr[k];
    end
    model_sample(d, clr_abs);
    if (ovr_try) m_ovr = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({lvl[k], env[k], peak[k], clip[k], vld[k], ovr[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset dut%0d: lvl=%0d env=%0d peak=%0d clip=%b vld=%b ovr=%b, all must be 0",
                 k, lvl[k], env[k], peak[k], clip[k], vld[k], ovr[k]);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(16'h4000, 1'b0, 1'b0);
    n_tests++;
    if (o_vpat[0] !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic latency: o_valid pattern %b, want 1000", o_vpat[0]);
    end
    n_tests++;
    if (o_env[0] !== 15'd16384) begin
      n_fail++;
      $display("FAIL basic env: got %0d want 16384", o_env[0]);
    end
    n_tests++;
    if (o_lvl[0] !== 5'(level_of(16384))) begin
      n_fail++;
      $display("FAIL basic level: got %0d want %0d", o_lvl[0], level_of(16384));
    end
    n_tests++;
    if (o_peak[0] !== 15'd16384) begin
      n_fail++;
      $display("FAIL basic peak: got %0d want 16384", o_peak[0]);
    end
    @(negedge clk);
    n_tests++;
    if (vld[0] !== 1'b0 || env[0] !== 15'd16384) begin
      n_fail++;
      $display("FAIL basic hold: vld=%b env=%0d, want vld=0 env=16384", vld[0], env[0]);
    end
  endtask

  task automatic test_clip();
    send(16'h8000, 1'b0, 1'b0);
    n_tests++;
    if (o_clip[0] !== 1'b1 || o_peak[0] !== 15'd32767) begin
      n_fail++;
      $display("FAIL clip set: clip=%b peak=%0d, want clip=1 peak=32767", o_clip[0], o_peak[0]);
    end
    n_tests++;
    if (o_env[0] !== 15'd32767 || o_lvl[0] !== 5'(level_of(32767))) begin
      n_fail++;
      $display("FAIL clip env: env=%0d lvl=%0d, want 32767/%0d", o_env[0], o_lvl[0], level_of(32767));
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_peak = 0;
    m_clip = 0;
    n_tests++;
    if (peak[0] !== 15'd0 || clip[0] !== 1'b0 || env[0] !== 15'd32767) begin
      n_fail++;
      $display("FAIL peak clear: peak=%0d clip=%b env=%0d, want 0/0/32767", peak[0], clip[0], env[0]);
    end
  endtask

  task automatic test_hold_decay();
    int d_seq [6]   = '{1000, 0, 0, 0, 0, 0};
    int env_exp [6] = '{1000, 1000, 1000, 500, 250, 125};
    int lvl_exp [6] = '{10, 10, 10, 9, 8, 7};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(16'(d_seq[i]), 1'b0, 1'b0);
      n_tests++;
      if (o_env[1] !== 15'(env_exp[i]) || o_lvl[1] !== 5'(lvl_exp[i])) begin
        n_fail++;
        $display("FAIL hold_decay step %0d: env=%0d lvl=%0d, want env=%0d lvl=%0d",
                 i, o_env[1], o_lvl[1], env_exp[i], lvl_exp[i]);
      end
    end
  endtask

  task automatic test_decay_floor();
    int d_seq [5]   = '{3, 0, 0, 0, 0};
    int env_exp [5] = '{3, 2, 1, 0, 0};
    int lvl_exp [5] = '{2, 2, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'(d_seq[i]), 1'b0, 1'b0);
      n_tests++;
      if (o_env[2] !== 15'(env_exp[i]) || o_lvl[2] !== 5'(lvl_exp[i])) begin
        n_fail++;
        $display("FAIL decay_floor step %0d: env=%0d lvl=%0d, want env=%0d lvl=%0d",
                 i, o_env[2], o_lvl[2], env_exp[i], lvl_exp[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send(16'h1234, 1'b0, 1'b1);
    n_tests++;
    if (o_vpat[0] !== 4'b1000 || o_env[0] !== 15'h1234 || o_peak[0] !== 15'h1234) begin
      n_fail++;
      $display("FAIL overrun first result: vpat=%b env=%0d peak=%0d, want 1000/4660/4660",
               o_vpat[0], o_env[0], o_peak[0]);
    end
    n_tests++;
    if (o_ovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun flag: got %b want 1", o_ovr[0]);
    end
    send(16'h0010, 1'b0, 1'b0);
    n_tests++;
    if (o_ovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun sticky: got %b want 1", o_ovr[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(16'd100, 1'b0, 1'b0);
    send(-16'sd200, 1'b0, 1'b0);
    n_tests++;
    if (o_vpat[0] !== 4'b1000 || o_ovr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back accept: vpat=%b ovr=%b, want 1000/0", o_vpat[0], o_ovr[0]);
    end
    n_tests++;
    if (o_env[0] !== 15'd200 || o_peak[0] !== 15'd200) begin
      n_fail++;
      $display("FAIL back_to_back value: env=%0d peak=%0d, want 200/200", o_env[0], o_peak[0]);
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    send(16'd500, 1'b0, 1'b0);
    send(16'h8000, 1'b1, 1'b0);
    n_tests++;
    if (o_peak[0] !== 15'd0 || o_clip[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_collision: peak=%0d clip=%b, want 0/0", o_peak[0], o_clip[0]);
    end
    n_tests++;
    if (o_env[0] !== 15'd32767) begin
      n_fail++;
      $display("FAIL clr_collision env: got %0d want 32767", o_env[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    do_reset();
    send(16'h2000, 1'b0, 1'b0);
    data  = 16'h3000;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({lvl[0], env[0], peak[0], clip[0], vld[0], ovr[0]} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: lvl=%0d env=%0d peak=%0d clip=%b vld=%b ovr=%b, want all 0",
               lvl[0], env[0], peak[0], clip[0], vld[0], ovr[0]);
    end
    rst = 1'b0;
    model_reset();
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) saw_valid = 1;
    end
    n_tests++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid stray o_valid: saw %b want 0", saw_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] ext [4] = '{16'h8000, 16'h7FFF, 16'h8001, 16'h0001};
    int gap;
    bit ca;
    bit ot;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 7) == 0) begin
          clr    = 1'b1;
          m_peak = 0;
          m_clip = 0;
        end
        @(negedge clk);
        clr = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: d = 16'($urandom);
        1: d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : -16'($urandom_range(0, 15));
        2: d = 16'd0;
        default: d = ext[$urandom_range(0, 3)];
      endcase
      ca = ($urandom_range(0, 9) == 0);
      ot = ($urandom_range(0, 5) == 0);
      send(d, ca, ot);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_vpat[k] !== 4'b1000 || o_env[k] !== 15'(m_env[k]) || o_lvl[k] !== 5'(level_of(m_env[k]))) begin
          n_fail++;
          $display("FAIL random it%0d dut%0d env: vpat=%b env=%0d lvl=%0d, want 1000 env=%0d lvl=%0d",
                   it, k, o_vpat[k], o_env[k], o_lvl[k], m_env[k], level_of(m_env[k]));
        end
        n_tests++;
        if (o_peak[k] !== 15'(m_peak) || o_clip[k] !== m_clip || o_ovr[k] !== m_ovr) begin
          n_fail++;
          $display("FAIL random it%0d dut%0d flags: peak=%0d clip=%b ovr=%b, want peak=%0d clip=%b ovr=%b",
                   it, k, o_peak[k], o_clip[k], o_ovr[k], m_peak, m_clip, m_ovr);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    clr   = 1'b0;
    data  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clip();
    test_hold_decay();
    test_decay_floor();
    test_overrun();
    test_back_to_back();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
